// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
//
// Game-flow sequencer for the Pong console. It steps through the
// serve / rally / point / game-over cycle and keeps both players' scores.
// It also gates the ball-motion datapath and the AI paddle with enable
// levels and a recentre strobe. Runs entirely in the pixel clock domain.
//
// Parameters
//   SERVE_FRAMES  frames the ball is held centred before a rally (1..255)
//   POINT_FRAMES  frames the game freezes after a point        (1..255)
//   WIN_SCORE     score that ends the match                    (1..15)
//
// Ports
//   clk_0        in   pixel clock (25.175 MHz), the only clock
//   rst          in   asynchronous, active-low reset
//   frame_tick   in   one-cycle pulse per frame (start of vblank)
//   start_btn    in   synchronised, debounced start button level
//   miss_left    in   one-cycle pulse: ball lost on the player (left) side
//   miss_right   in   one-cycle pulse: ball lost on the AI (right) side
//   ball_run     out  ball motion enable (RALLY only)
//   ball_reset   out  one-cycle recentre strobe on the first SERVE cycle
//   serve_dir    out  serve direction, 0 = left, 1 = right
//   ai_enable    out  AI paddle tracking enable (SERVE and RALLY)
//   score_left   out  player score
//   score_right  out  AI score
//   game_over    out  match finished (OVER only)
//   winner       out  valid while game_over: 0 = left, 1 = right
//   state        out  current state code, for display/debug
//
// All outputs come straight from flops. The enable/strobe outputs are
// decoded from the next state, so they change on the same edge as the
// state itself.
// -----------------------------------------------------------------------------
module match_controller #(
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       ai_enable,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    // State encoding. The codes are visible on the state port.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_RALLY = 3'd2;
    localparam logic [2:0] ST_POINT = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [7:0] SERVE_LIMIT = 8'(SERVE_FRAMES);
    localparam logic [7:0] POINT_LIMIT = 8'(POINT_FRAMES);
    localparam logic [3:0] WIN_LIMIT   = 4'(WIN_SCORE);

    // Registered state and datapath
    logic [2:0] state_q,       state_d;
    logic       start_prev_q,  start_prev_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;
    logic [3:0] score_left_q,  score_left_d;
    logic [3:0] score_right_q, score_right_d;
    logic       serve_dir_q,   serve_dir_d;

    // Registered outputs
    logic       ball_run_q,    ball_run_d;
    logic       ball_reset_q,  ball_reset_d;
    logic       ai_enable_q,   ai_enable_d;
    logic       game_over_q,   game_over_d;
    logic       winner_q,      winner_d;

    // Shared decode terms
    logic       start_edge;
    logic [7:0] frame_cnt_inc;
    logic       serve_done;
    logic       point_done;
    logic [3:0] score_left_inc;
    logic [3:0] score_right_inc;
    logic       left_wins;
    logic       right_wins;
    logic       state_entry;

    // start_prev_q resets to 1, so a button held through reset gives no edge.
    assign start_edge    = start_btn & ~start_prev_q;
    assign start_prev_d  = start_btn;

    // A state exits when the tick being counted brings the count to its limit.
    assign frame_cnt_inc = frame_cnt_q + 8'd1;
    assign serve_done    = frame_tick && (frame_cnt_inc == SERVE_LIMIT);
    assign point_done    = frame_tick && (frame_cnt_inc == POINT_LIMIT);

    // Saturating increments: the limit check happens before the store, so a
    // score can never climb past WIN_LIMIT or wrap in four bits.
    assign score_left_inc  = (score_left_q  < WIN_LIMIT) ? (score_left_q  + 4'd1) : score_left_q;
    assign score_right_inc = (score_right_q < WIN_LIMIT) ? (score_right_q + 4'd1) : score_right_q;
    assign left_wins       = (score_left_inc  == WIN_LIMIT);
    assign right_wins      = (score_right_inc == WIN_LIMIT);

    // Any state change, including recovery from an illegal code, is an entry.
    assign state_entry     = (state_d != state_q);

    // State register
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; miss_left has priority when both misses coincide.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (serve_done) begin
                    state_d = ST_RALLY;
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_RALLY: begin
                if (miss_left) begin
                    state_d = right_wins ? ST_OVER : ST_POINT;
                end else if (miss_right) begin
                    state_d = left_wins ? ST_OVER : ST_POINT;
                end else begin
                    state_d = ST_RALLY;
                end
            end
            ST_POINT: begin
                if (point_done) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_POINT;
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame counter, scores and serve direction.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        serve_dir_d   = serve_dir_q;

        // A tick on the entry edge is swallowed by the reload to zero.
        if (state_entry) begin
            frame_cnt_d = 8'd0;
        end else if (frame_tick && ((state_q == ST_SERVE) || (state_q == ST_POINT))) begin
            frame_cnt_d = frame_cnt_inc;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    serve_dir_d   = 1'b1;
                end else begin
                    serve_dir_d   = serve_dir_q;
                end
            end
            ST_RALLY: begin
                if (miss_left) begin
                    score_right_d = score_right_inc;
                    serve_dir_d   = 1'b0;
                end else if (miss_right) begin
                    score_left_d  = score_left_inc;
                    serve_dir_d   = 1'b1;
                end else begin
                    serve_dir_d   = serve_dir_q;
                end
            end
            default: begin
                serve_dir_d = serve_dir_q;
            end
        endcase
    end

    // Output decode from the next state so outputs move with the state.
    always_comb begin
        ball_run_d   = 1'b0;
        ai_enable_d  = 1'b0;
        game_over_d  = 1'b0;
        winner_d     = 1'b0;
        // Recentre strobe only on the edge that enters SERVE.
        ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        case (state_d)
            ST_SERVE: begin
                ai_enable_d = 1'b1;
            end
            ST_RALLY: begin
                ball_run_d  = 1'b1;
                ai_enable_d = 1'b1;
            end
            ST_OVER: begin
                game_over_d = 1'b1;
                winner_d    = (score_right_d == WIN_LIMIT);
            end
            default: begin
                ball_run_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            start_prev_q  <= 1'b1;
            frame_cnt_q   <= 8'd0;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            serve_dir_q   <= 1'b1;
            ball_run_q    <= 1'b0;
            ball_reset_q  <= 1'b0;
            ai_enable_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
        end else begin
            start_prev_q  <= start_prev_d;
            frame_cnt_q   <= frame_cnt_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            serve_dir_q   <= serve_dir_d;
            ball_run_q    <= ball_run_d;
            ball_reset_q  <= ball_reset_d;
            ai_enable_q   <= ai_enable_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign ball_run    = ball_run_q;
    assign ball_reset  = ball_reset_q;
    assign serve_dir   = serve_dir_q;
    assign ai_enable   = ai_enable_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule
